// File: rtl/reset_sync_chain.sv
// rtl/reset_sync_chain.sv - reset synchronizer flop chain with active-high async preset
//
// Purpose: STAGES-deep shift chain. A 1 bit means "reset asserted".
//          preset_i forces every bit to 1 at once, with no clock edge.
//          rst_n_i low at a rising edge loads every bit with 1.
//          Otherwise the chain shifts in 0 ("inactive") on each rising edge.
// Ports:
//   clk_i       sole clock, rising edge
//   rst_n_i     synchronous active-low reset, loads the chain with "asserted"
//   preset_i    asynchronous active-high preset, has priority over rst_n_i
//   asserted_o  last chain bit, 1 = reset asserted
module reset_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic preset_i,
    output logic asserted_o
);

    (* ASYNC_REG = "TRUE", keep = "true" *) logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], 1'b0};
        if (!rst_n_i) begin
            chain_d = '1;
        end
    end

    // The preset is the only asynchronous path; release always walks the
    // full chain so the deassertion is aligned to clk_i.
    always_ff @(posedge clk_i or posedge preset_i) begin
        if (preset_i) begin
            chain_q <= '1;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign asserted_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_cdc.sv
// rtl/reset_cdc.sv - asynchronous-assert, synchronous-release reset crossing
//
// Purpose: brings a reset request from a foreign domain into the clk domain.
//          rst_out asserts immediately when rst_in asserts and releases on
//          the STAGES-th rising clk edge after rst_in goes inactive.
// Parameters (positional order): IN_ACTIVE_HIGH, OUT_ACTIVE_HIGH, STAGES (2..8)
// Ports:
//   clk      sole clock, rising edge
//   rst_n    synchronous active-low block reset
//   rst_in   asynchronous reset request, polarity per IN_ACTIVE_HIGH
//   rst_out  clk-domain reset, polarity per OUT_ACTIVE_HIGH
module reset_cdc #(
    parameter bit IN_ACTIVE_HIGH  = 1'b1,
    parameter bit OUT_ACTIVE_HIGH = 1'b1,
    parameter int STAGES          = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_in,
    output logic rst_out
);

    logic req_asserted;
    logic sync_asserted;

    // Normalize both polarities to "1 = asserted" around the chain.
    assign req_asserted = IN_ACTIVE_HIGH ? rst_in : ~rst_in;

    reset_sync_chain #(
        .STAGES(STAGES)
    ) u_chain (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .preset_i   (req_asserted),
        .asserted_o (sync_asserted)
    );

    assign rst_out = OUT_ACTIVE_HIGH ? sync_asserted : ~sync_asserted;

endmodule

// File: tb/tb_reset_cdc.sv
// tb/tb_reset_cdc.sv - scoreboard testbench for reset_cdc
module tb_reset_cdc;

    logic clk;
    logic rst_n_a, rst_in_a, rst_out_a;
    logic rst_n_b, rst_in_b, rst_out_b;

    int n_cmp;
    int n_fail;

    logic exp_q[$];
    logic exp_val;

    reset_cdc dut_a (
        .clk     (clk),
        .rst_n   (rst_n_a),
        .rst_in  (rst_in_a),
        .rst_out (rst_out_a)
    );

    reset_cdc #(1'b0, 1'b0, 3) dut_b (
        .clk     (clk),
        .rst_n   (rst_n_b),
        .rst_in  (rst_in_b),
        .rst_out (rst_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Moves to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n_a = 1'b0; rst_in_a = 1'b0;
        rst_n_b = 1'b0; rst_in_b = 1'b1;
        step();
        exp_q.push_back(1'b1);
        exp_val = exp_q.pop_front();
        n_cmp++;
        if (rst_out_a !== exp_val) begin
            n_fail++;
            $display("FAIL reset_a_load: got %b want %b", rst_out_a, exp_val);
        end
        exp_q.push_back(1'b0);
        exp_val = exp_q.pop_front();
        n_cmp++;
        if (rst_out_b !== exp_val) begin
            n_fail++;
            $display("FAIL reset_b_load: got %b want %b", rst_out_b, exp_val);
        end
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        // After rst_n returns: A releases on edge 2, B (active-low out) on edge 3.
        exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_val = exp_q.pop_front();
            n_cmp++;
            if (rst_out_a !== exp_val) begin
                n_fail++;
                $display("FAIL reset_a_release edge%0d: got %b want %b", i + 1, rst_out_a, exp_val);
            end
            exp_val = exp_q.pop_front();
            n_cmp++;
            if (rst_out_b !== exp_val) begin
                n_fail++;
                $display("FAIL reset_b_release edge%0d: got %b want %b", i + 1, rst_out_b, exp_val);
            end
        end
    endtask

    task automatic test_async_assert();
        step();
        rst_in_a = 1'b1;
        exp_q.push_back(1'b1);
        #1;
        exp_val = exp_q.pop_front();
        n_cmp++;
        if (rst_out_a !== exp_val) begin
            n_fail++;
            $display("FAIL async_assert: got %b want %b", rst_out_a, exp_val);
        end
        // Held through clock edges and an rst_n pulse.
        rst_n_a = 1'b0;
        exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 1) rst_n_a = 1'b1;
            exp_val = exp_q.pop_front();
            n_cmp++;
            if (rst_out_a !== exp_val) begin
                n_fail++;
                $display("FAIL async_hold edge%0d: got %b want %b", i + 1, rst_out_a, exp_val);
            end
        end
        rst_n_a = 1'b1;
    endtask

    task automatic test_release();
        // Entered at edge+1 with rst_in_a asserted.
        rst_in_a = 1'b0;
        exp_q.push_back(1'b1);
        #1;
        exp_val = exp_q.pop_front();
        n_cmp++;
        if (rst_out_a !== exp_val) begin
            n_fail++;
            $display("FAIL release_no_comb: got %b want %b", rst_out_a, exp_val);
        end
        exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_val = exp_q.pop_front();
            n_cmp++;
            if (rst_out_a !== exp_val) begin
                n_fail++;
                $display("FAIL release edge%0d: got %b want %b", i + 1, rst_out_a, exp_val);
            end
        end
    endtask

    task automatic test_restart();
        rst_in_a = 1'b1;
        step();
        rst_in_a = 1'b0;
        step();
        exp_q.push_back(1'b1);
        exp_val = exp_q.pop_front();
        n_cmp++;
        if (rst_out_a !== exp_val) begin
            n_fail++;
            $display("FAIL restart_first_edge: got %b want %b", rst_out_a, exp_val);
        end
        // Short pulse between edges after the first release edge.
        rst_in_a = 1'b1;
        #1;
        exp_q.push_back(1'b1);
        exp_val = exp_q.pop_front();
        n_cmp++;
        if (rst_out_a !== exp_val) begin
            n_fail++;
            $display("FAIL restart_pulse: got %b want %b", rst_out_a, exp_val);
        end
        #1;
        rst_in_a = 1'b0;
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            exp_val = exp_q.pop_front();
            n_cmp++;
            if (rst_out_a !== exp_val) begin
                n_fail++;
                $display("FAIL restart edge%0d: got %b want %b", i + 1, rst_out_a, exp_val);
            end
        end
    endtask

    task automatic test_polarity();
        step();
        rst_in_b = 1'b0;
        #1;
        exp_q.push_back(1'b0);
        exp_val = exp_q.pop_front();
        n_cmp++;
        if (rst_out_b !== exp_val) begin
            n_fail++;
            $display("FAIL polarity_assert: got %b want %b", rst_out_b, exp_val);
        end
        step();
        rst_in_b = 1'b1;
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            exp_val = exp_q.pop_front();
            n_cmp++;
            if (rst_out_b !== exp_val) begin
                n_fail++;
                $display("FAIL polarity_release edge%0d: got %b want %b", i + 1, rst_out_b, exp_val);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 10; it++) begin
            step();
            rst_in_a = 1'b1;
            #1;
            exp_q.push_back(1'b1);
            exp_val = exp_q.pop_front();
            n_cmp++;
            if (rst_out_a !== exp_val) begin
                n_fail++;
                $display("FAIL b2b_assert it%0d: got %b want %b", it, rst_out_a, exp_val);
            end
            step();
            rst_in_a = 1'b0;
            for (int k = 0; k < 10; k++) exp_q.push_back(k == 0);
            for (int k = 0; k < 10; k++) begin
                step();
                exp_val = exp_q.pop_front();
                n_cmp++;
                if (rst_out_a !== exp_val) begin
                    n_fail++;
                    $display("FAIL b2b it%0d edge%0d: got %b want %b", it, k + 1, rst_out_a, exp_val);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n_a = 1'b0; rst_in_a = 1'b0;
        rst_n_b = 1'b0; rst_in_b = 1'b1;
        test_reset();
        test_async_assert();
        test_release();
        test_restart();
        test_polarity();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
